// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encodings for the bit-serial adder controller.
package serial_adder_pkg;
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/Half_Adder.sv
// Half_Adder: 1-bit half adder.
//   a, b  : addend bits
//   sum   : a xor b
//   carry : a and b
module Half_Adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/full_adder_slice.sv
// full_adder_slice: 1-bit full adder built from two Half_Adder instances and an OR.
//   a, b, cin : slice inputs
//   sum, cout : slice sum and carry out
module full_adder_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0, c0, c1;
  Half_Adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
  Half_Adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));
  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full-adder slice LSB-first over WIDTH cycles to add two operands.
//   clk, rst           : clock, asynchronous active-high reset
//   Start              : request, sampled only when idle
//   Input_A, Input_B   : operands, captured on the accepted Start edge
//   Busy               : high while an addition is in flight (RUN and DONE)
//   Done               : one-cycle pulse marking Output_S/Output_C (and Output_V) valid
//   Output_S, Output_C : registered sum and carry out, held until the next result
//   Output_V           : signed overflow, only when SERIAL_ADDER_OVF_EN is defined
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Input_A,
  input  logic [WIDTH-1:0] Input_B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Output_S,
  output logic             Output_C
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Output_V
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             carry;
  logic [CW-1:0]    bit_cnt;
  logic             fa_s, fa_c;
`ifdef SERIAL_ADDER_OVF_EN
  logic             c_msb;
`endif
  full_adder_slice u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .sum(fa_s), .cout(fa_c));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      carry    <= 1'b0;
      bit_cnt  <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Output_S <= '0;
      Output_C <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      c_msb    <= 1'b0;
      Output_V <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: if (Start) begin
          a_sh    <= Input_A;
          b_sh    <= Input_B;
          carry   <= 1'b0;
          bit_cnt <= '0;
          Busy    <= 1'b1;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          // sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts
          s_sh    <= {fa_s, s_sh[WIDTH-1:1]};
          carry   <= fa_c;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          bit_cnt <= bit_cnt + 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          // last write happens in the final RUN cycle: the carry into the MSB
          c_msb   <= carry;
`endif
          if (bit_cnt == CW'(WIDTH - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          Output_S <= s_sh;
          Output_C <= carry;
`ifdef SERIAL_ADDER_OVF_EN
          Output_V <= c_msb ^ carry;
`endif
          Done     <= 1'b1;
          Busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl (WIDTH=8), checks Output_V when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic         clk = 1'b0, rst = 1'b1, Start = 1'b0;
  logic [W-1:0] Input_A = '0, Input_B = '0;
  logic         Busy, Done, Output_C;
  logic [W-1:0] Output_S;
`ifdef SERIAL_ADDER_OVF_EN
  logic         Output_V;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Input_A(Input_A), .Input_B(Input_B),
    .Busy(Busy), .Done(Done), .Output_S(Output_S), .Output_C(Output_C)
`ifdef SERIAL_ADDER_OVF_EN
    , .Output_V(Output_V)
`endif
  );
  typedef struct {logic [W-1:0] s; logic c; logic v; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, free_at = 0, acc = -1;
  logic [W:0] m_sum;
  logic m_v;
  logic [W-1:0] last_s = '0;
  logic last_c = 1'b0, last_v = 1'b0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic issue(logic [W-1:0] a, logic [W-1:0] b);
    Start = 1'b1; Input_A = a; Input_B = b;
    step(1);
    Start = 1'b0; Input_A = W'($urandom); Input_B = W'($urandom);
    step(W + 2);
  endtask
  // reference: a request is taken only if W+2 cycles have passed since the last one;
  // its result appears W+1 cycles after acceptance as plain integer addition
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete(); free_at = 0; acc = -1;
    end else if (Start && cyc >= free_at) begin
      m_sum = {1'b0, Input_A} + {1'b0, Input_B};
      m_v = (Input_A[W-1] == Input_B[W-1]) && (m_sum[W-1] != Input_A[W-1]);
      q.push_back('{m_sum[W-1:0], m_sum[W], m_v, cyc + W + 1});
      acc = cyc; free_at = cyc + W + 2;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      last_s = '0; last_c = 1'b0; last_v = 1'b0;
    end else begin
      chk("busy", 64'(Busy), 64'(acc >= 0 && cyc >= acc && cyc <= acc + W));
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("done_pulse", 64'(Done), 64'(1));
        last_s = e.s; last_c = e.c; last_v = e.v;
      end else chk("done_quiet", 64'(Done), 64'(0));
      chk("sum", 64'(Output_S), 64'(last_s));
      chk("carry", 64'(Output_C), 64'(last_c));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", 64'(Output_V), 64'(last_v));
`endif
    end
  end
  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, 64'(Busy), 64'(0));
    chk({tag, "_done"}, 64'(Done), 64'(0));
    chk({tag, "_sum"}, 64'(Output_S), 64'(0));
    chk({tag, "_carry"}, 64'(Output_C), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 64'(Output_V), 64'(0));
`endif
  endtask
  initial begin
    #1 chk_zero("reset");
    step(2);
    rst = 1'b0;
    Start = 1'b1; Input_A = 8'h05; Input_B = 8'h03;
    step(1);
    Start = 1'b0; Input_A = W'($urandom); Input_B = W'($urandom);
    step(2);
    Start = 1'b1; Input_A = 8'h55; Input_B = 8'h66;
    step(1);
    Start = 1'b0;
    step(W + 2);
    issue(8'hFF, 8'h01);
    issue(8'h7F, 8'h01);
    issue(8'h80, 8'h80);
    Start = 1'b1; Input_A = 8'h05; Input_B = 8'h03;
    step(1);
    Start = 1'b0;
    step(3);
    rst = 1'b1;
    #1 chk_zero("abort");
    step(2);
    rst = 1'b0;
    issue(8'h0A, 8'h0B);
    Start = 1'b1; Input_A = 8'h10; Input_B = 8'h20;
    step(35);
    Start = 1'b0;
    step(W + 2);
    repeat (200) begin
      Start = ($urandom_range(0, 2) == 0);
      Input_A = W'($urandom); Input_B = W'($urandom);
      step(1);
    end
    Start = 1'b0;
    for (int i = 0; i < 100 && q.size() > 0; i++) step(1);
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
